// File: rtl/outsel_xbar_decode_pkg.sv
// Shared router definitions for the outSel crossbar decode block: port count,
// index width, flit width, port names and a small multi-hot helper.
package outsel_xbar_decode_pkg;

  localparam int NUM_PORT     = 5;
  localparam int LOG_NUM_PORT = 3;
  localparam int FLIT_W       = 64;

  typedef logic [LOG_NUM_PORT-1:0] port_idx_t;
  typedef logic [NUM_PORT-1:0]     port_vec_t;
  typedef logic [FLIT_W-1:0]       flit_t;

  // Router port names; PORT_L is the MSB lane and therefore the highest priority.
  localparam port_idx_t PORT_N = 3'd0;
  localparam port_idx_t PORT_E = 3'd1;
  localparam port_idx_t PORT_S = 3'd2;
  localparam port_idx_t PORT_W = 3'd3;
  localparam port_idx_t PORT_L = 3'd4;

  // True when two or more bits of v are set.
  function automatic logic multi_hot(port_vec_t v);
    return |(v & (v - port_vec_t'(1)));
  endfunction

endpackage

// File: rtl/outsel_xbar_decode_if.sv
// Crossbar bus: per-lane flits with binary outSel in, per-output flits out.
interface outsel_xbar_decode_if;
  import outsel_xbar_decode_pkg::*;

  logic [NUM_PORT-1:0]              in_valid;
  logic [NUM_PORT*LOG_NUM_PORT-1:0] in_outSel;
  logic [NUM_PORT*FLIT_W-1:0]       in_flit;
  logic [NUM_PORT-1:0]              out_valid;
  logic [NUM_PORT*FLIT_W-1:0]       out_flit;
  logic [NUM_PORT*LOG_NUM_PORT-1:0] out_src;

  modport master (
    output in_valid, in_outSel, in_flit,
    input  out_valid, out_flit, out_src
  );

  modport slave (
    input  in_valid, in_outSel, in_flit,
    output out_valid, out_flit, out_src
  );
endinterface

// File: rtl/outsel_onehot_dec.sv
// One lane's outSel decoder: binary index to one-hot, gated by lane valid.
// Indices past the last port produce no one-hot bit and raise illegal.
module outsel_onehot_dec
  import outsel_xbar_decode_pkg::*;
(
  input  logic      valid,
  input  port_idx_t sel,
  output port_vec_t onehot,
  output logic      illegal
);

  // Decode the index; an invalid lane contributes nothing.
  always_comb begin
    // NOTE: every output gets a default before any conditional logic, so no
    // path leaves a signal unassigned and no latch is inferred.
    onehot  = '0;
    illegal = valid && (sel >= port_idx_t'(NUM_PORT));
    for (int j = 0; j < NUM_PORT; j++) begin
      onehot[j] = valid && (sel == port_idx_t'(j));
    end
  end

endmodule

// File: rtl/outsel_xbar_decode.sv
// Crossbar output stage of the bufferless router: decodes each lane's outSel,
// transposes the grant matrix, picks the highest-index lane per output and
// registers one flit per output port. Conflict/illegal monitors and saturating
// per-output delivered-flit counters are provided for debug.
module outsel_xbar_decode
  import outsel_xbar_decode_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  outsel_xbar_decode_if.slave  bus,
  output logic                 conflict,
  output logic                 illegal,
  output logic                 err_sticky,
  input  logic                 err_clr,
  input  port_idx_t            stat_sel,
  output logic [CNT_W-1:0]     stat_cnt
);

  localparam int L = LOG_NUM_PORT;

  port_vec_t                 lane_hot [NUM_PORT];
  port_vec_t                 lane_ill;
  port_vec_t                 grant_vld;
  port_vec_t                 port_conflict;
  logic [NUM_PORT*L-1:0]     grant_src;
  logic [NUM_PORT*FLIT_W-1:0] grant_flit;

  logic [NUM_PORT-1:0]        out_valid_q, out_valid_d;
  logic [NUM_PORT*FLIT_W-1:0] out_flit_q,  out_flit_d;
  logic [NUM_PORT*L-1:0]      out_src_q,   out_src_d;
  logic                       conflict_q,  conflict_d;
  logic                       illegal_q,   illegal_d;
  logic                       err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0]           cnt_q [NUM_PORT];
  logic [CNT_W-1:0]           cnt_d [NUM_PORT];

  for (genvar i = 0; i < NUM_PORT; i++) begin : g_lane
    outsel_onehot_dec u_dec (
      .valid   (bus.in_valid[i]),
      .sel     (bus.in_outSel[i*L +: L]),
      .onehot  (lane_hot[i]),
      .illegal (lane_ill[i])
    );
  end

  for (genvar j = 0; j < NUM_PORT; j++) begin : g_out
    port_vec_t req;
    port_idx_t src;
    flit_t     flit;

    // Column j of the grant matrix; the last requester scanned (highest lane) wins.
    always_comb begin
      req  = '0;
      src  = '0;
      flit = '0;
      for (int i = 0; i < NUM_PORT; i++) begin
        req[i] = lane_hot[i][j];
        if (lane_hot[i][j]) begin
          src  = port_idx_t'(i);
          flit = bus.in_flit[i*FLIT_W +: FLIT_W];
        end
      end
    end

    assign grant_vld[j]                   = |req;
    assign port_conflict[j]               = multi_hot(req);
    assign grant_src[j*L +: L]            = src;
    assign grant_flit[j*FLIT_W +: FLIT_W] = flit;
  end

  // Next output state; idle outputs hold payload and source to avoid toggling.
  always_comb begin
    out_valid_d = grant_vld;
    out_src_d   = out_src_q;
    out_flit_d  = out_flit_q;
    for (int j = 0; j < NUM_PORT; j++) begin
      if (grant_vld[j]) begin
        out_src_d[j*L +: L]            = grant_src[j*L +: L];
        out_flit_d[j*FLIT_W +: FLIT_W] = grant_flit[j*FLIT_W +: FLIT_W];
      end
      cnt_d[j] = (grant_vld[j] && (cnt_q[j] != '1)) ? cnt_q[j] + 1'b1 : cnt_q[j];
    end
    conflict_d = |port_conflict;
    illegal_d  = |lane_ill;
    // A new error outranks a coincident clear.
    if (conflict_d || illegal_d) err_sticky_d = 1'b1;
    else if (err_clr)            err_sticky_d = 1'b0;
    else                         err_sticky_d = err_sticky_q;
  end

  // Output, monitor and counter registers; reset discards in-flight flits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q  <= '0;
      out_flit_q   <= '0;
      out_src_q    <= '0;
      conflict_q   <= 1'b0;
      illegal_q    <= 1'b0;
      err_sticky_q <= 1'b0;
      for (int j = 0; j < NUM_PORT; j++) cnt_q[j] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      out_valid_q  <= out_valid_d;
      out_flit_q   <= out_flit_d;
      out_src_q    <= out_src_d;
      conflict_q   <= conflict_d;
      illegal_q    <= illegal_d;
      err_sticky_q <= err_sticky_d;
      for (int j = 0; j < NUM_PORT; j++) cnt_q[j] <= cnt_d[j];
    end
  end

  // Debug counter read port; out-of-range selects read as zero.
  always_comb begin
    stat_cnt = '0;
    for (int j = 0; j < NUM_PORT; j++) begin
      if (stat_sel == port_idx_t'(j)) stat_cnt = cnt_q[j];
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_flit  = out_flit_q;
  assign bus.out_src   = out_src_q;
  assign conflict      = conflict_q;
  assign illegal       = illegal_q;
  assign err_sticky    = err_sticky_q;

endmodule

// File: tb/tb_outsel_xbar_decode.sv
// Bench for outsel_xbar_decode: directed scenarios plus randomized traffic
// against a behavioural model of the crossbar decode rules.
module tb_outsel_xbar_decode;
  import outsel_xbar_decode_pkg::*;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int L       = LOG_NUM_PORT;
  localparam int F       = FLIT_W;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             err_clr = 1'b0;
  port_idx_t        stat_sel = '0;
  logic             conflict, illegal, err_sticky;
  logic [CNT_W-1:0] stat_cnt;

  outsel_xbar_decode_if bus ();

  outsel_xbar_decode #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .conflict   (conflict),
    .illegal    (illegal),
    .err_sticky (err_sticky),
    .err_clr    (err_clr),
    .stat_sel   (stat_sel),
    .stat_cnt   (stat_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [NUM_PORT-1:0]   exp_valid;
  logic [NUM_PORT*F-1:0] exp_flit;
  logic [NUM_PORT*L-1:0] exp_src;
  logic                  exp_conflict, exp_illegal, exp_sticky;
  int                    exp_cnt [NUM_PORT];
  int                    exp_in_pop;
  flit_t                 lane_flit [NUM_PORT];

  function automatic int lane_sel(int i);
    return int'(bus.in_outSel[i*L +: L]);
  endfunction

  function automatic int exp_stat();
    return (int'(stat_sel) < NUM_PORT) ? exp_cnt[int'(stat_sel)] : 0;
  endfunction

  task automatic model_reset();
    exp_valid    = '0;
    exp_flit     = '0;
    exp_src      = '0;
    exp_conflict = 1'b0;
    exp_illegal  = 1'b0;
    exp_sticky   = 1'b0;
    exp_in_pop   = 0;
    for (int j = 0; j < NUM_PORT; j++) exp_cnt[j] = 0;
  endtask

  // For each output, scan lanes from the top down; the first match wins.
  task automatic model_step();
    int hits;
    bit found;
    if (!reset_n) begin
      model_reset();
      return;
    end
    exp_conflict = 1'b0;
    exp_illegal  = 1'b0;
    exp_in_pop   = $countones(bus.in_valid);
    for (int j = 0; j < NUM_PORT; j++) begin
      hits  = 0;
      found = 1'b0;
      for (int i = NUM_PORT - 1; i >= 0; i--) begin
        if (bus.in_valid[i] && lane_sel(i) == j) begin
          hits++;
          if (!found) begin
            found = 1'b1;
            exp_src[j*L +: L]  = L'(i);
            exp_flit[j*F +: F] = bus.in_flit[i*F +: F];
          end
        end
      end
      exp_valid[j] = found;
      if (found && exp_cnt[j] < CNT_MAX) exp_cnt[j]++;
      if (hits >= 2) exp_conflict = 1'b1;
    end
    for (int i = 0; i < NUM_PORT; i++)
      if (bus.in_valid[i] && lane_sel(i) >= NUM_PORT) exp_illegal = 1'b1;
    if (exp_conflict || exp_illegal) exp_sticky = 1'b1;
    else if (err_clr)                exp_sticky = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive_idle();
    bus.in_valid  = '0;
    bus.in_outSel = '0;
    bus.in_flit   = '0;
    err_clr       = 1'b0;
  endtask

  task automatic set_lane(int i, int sel);
    lane_flit[i] = {$urandom, $urandom};
    bus.in_valid[i]           = 1'b1;
    bus.in_outSel[i*L +: L]   = L'(sel);
    bus.in_flit[i*F +: F]     = lane_flit[i];
  endtask

  task automatic drive_random(bit legal_bias);
    bus.in_valid = NUM_PORT'($urandom);
    for (int i = 0; i < NUM_PORT; i++) begin
      if (legal_bias && $urandom_range(0, 15) < 13)
        bus.in_outSel[i*L +: L] = L'($urandom_range(0, NUM_PORT - 1));
      else
        bus.in_outSel[i*L +: L] = L'($urandom_range(0, 7));
      bus.in_flit[i*F +: F] = {$urandom, $urandom};
    end
    err_clr  = ($urandom_range(0, 7) == 0);
    stat_sel = L'($urandom_range(0, 7));
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    drive_random(1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
      drive_random(1'b0);
    end
    n_checks++; if (bus.out_valid !== '0) $display("FAIL reset_out_valid got %h want 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_flit !== '0) $display("FAIL reset_out_flit got %h want 0", bus.out_flit); else n_pass++;
    n_checks++; if (bus.out_src !== '0) $display("FAIL reset_out_src got %h want 0", bus.out_src); else n_pass++;
    n_checks++; if ({conflict, illegal, err_sticky} !== 3'b000)
      $display("FAIL reset_monitors got %b want 000", {conflict, illegal, err_sticky}); else n_pass++;
    for (int s = 0; s < 8; s++) begin
      stat_sel = L'(s);
      #1;
      n_checks++; if (stat_cnt !== '0) $display("FAIL reset_stat_cnt sel=%0d got %0d want 0", s, stat_cnt); else n_pass++;
    end
    drive_idle();
    reset_n = 1'b1;
    tick();
    n_checks++; if (bus.out_valid !== '0) $display("FAIL idle_out_valid got %h want 0", bus.out_valid); else n_pass++;
    for (int s = 0; s < 8; s++) begin
      stat_sel = L'(s);
      #1;
      n_checks++; if (stat_cnt !== '0) $display("FAIL idle_stat_cnt sel=%0d got %0d want 0", s, stat_cnt); else n_pass++;
    end
  endtask

  task automatic test_permutation();
    drive_idle();
    for (int i = 0; i < NUM_PORT; i++) set_lane(i, NUM_PORT - 1 - i);
    tick();
    drive_idle();
    n_checks++; if (bus.out_valid !== 5'b11111) $display("FAIL perm_out_valid got %b want 11111", bus.out_valid); else n_pass++;
    n_checks++; if (conflict !== 1'b0) $display("FAIL perm_conflict got %b want 0", conflict); else n_pass++;
    for (int j = 0; j < NUM_PORT; j++) begin
      n_checks++; if (bus.out_src[j*L +: L] !== L'(NUM_PORT - 1 - j))
        $display("FAIL perm_out_src[%0d] got %0d want %0d", j, bus.out_src[j*L +: L], NUM_PORT - 1 - j); else n_pass++;
      n_checks++; if (bus.out_flit[j*F +: F] !== lane_flit[NUM_PORT - 1 - j])
        $display("FAIL perm_out_flit[%0d] got %h want %h", j, bus.out_flit[j*F +: F], lane_flit[NUM_PORT - 1 - j]); else n_pass++;
    end
  endtask

  task automatic test_conflict();
    drive_idle();
    set_lane(1, 2);
    set_lane(3, 2);
    tick();
    drive_idle();
    n_checks++; if (bus.out_valid !== 5'b00100) $display("FAIL conf_out_valid got %b want 00100", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_src[2*L +: L] !== 3'd3) $display("FAIL conf_out_src got %0d want 3", bus.out_src[2*L +: L]); else n_pass++;
    n_checks++; if (bus.out_flit[2*F +: F] !== lane_flit[3]) $display("FAIL conf_out_flit got %h want %h", bus.out_flit[2*F +: F], lane_flit[3]); else n_pass++;
    n_checks++; if (conflict !== 1'b1) $display("FAIL conf_pulse got %b want 1", conflict); else n_pass++;
    n_checks++; if (err_sticky !== 1'b1) $display("FAIL conf_sticky got %b want 1", err_sticky); else n_pass++;
    tick();
    n_checks++; if (conflict !== 1'b0) $display("FAIL conf_pulse_end got %b want 0", conflict); else n_pass++;
    n_checks++; if (err_sticky !== 1'b1) $display("FAIL conf_sticky_hold got %b want 1", err_sticky); else n_pass++;
    n_checks++; if (bus.out_flit !== exp_flit) $display("FAIL idle_flit_hold got %h want %h", bus.out_flit, exp_flit); else n_pass++;
  endtask

  task automatic test_illegal();
    drive_idle();
    err_clr = 1'b1;
    tick();
    n_checks++; if (err_sticky !== 1'b0) $display("FAIL clr_sticky got %b want 0", err_sticky); else n_pass++;
    drive_idle();
    set_lane(0, 6);
    tick();
    drive_idle();
    n_checks++; if (bus.out_valid !== '0) $display("FAIL ill_out_valid got %b want 0", bus.out_valid); else n_pass++;
    n_checks++; if (illegal !== 1'b1) $display("FAIL ill_pulse got %b want 1", illegal); else n_pass++;
    n_checks++; if (conflict !== 1'b0) $display("FAIL ill_conflict got %b want 0", conflict); else n_pass++;
    n_checks++; if (err_sticky !== 1'b1) $display("FAIL ill_sticky got %b want 1", err_sticky); else n_pass++;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_checks++; if (illegal !== 1'b0) $display("FAIL ill_pulse_end got %b want 0", illegal); else n_pass++;
    n_checks++; if (err_sticky !== 1'b0) $display("FAIL ill_clr_sticky got %b want 0", err_sticky); else n_pass++;
  endtask

  task automatic test_clear_vs_error();
    drive_idle();
    set_lane(0, 1);
    set_lane(4, 1);
    err_clr = 1'b1;
    tick();
    n_checks++; if (err_sticky !== 1'b1) $display("FAIL clr_set_sticky got %b want 1", err_sticky); else n_pass++;
    n_checks++; if (bus.out_src[1*L +: L] !== 3'd4) $display("FAIL clr_set_src got %0d want 4", bus.out_src[1*L +: L]); else n_pass++;
    tick();
    n_checks++; if (err_sticky !== 1'b1) $display("FAIL clr_hold_sticky got %b want 1", err_sticky); else n_pass++;
    n_checks++; if (conflict !== 1'b1) $display("FAIL clr_hold_conflict got %b want 1", conflict); else n_pass++;
    drive_idle();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_checks++; if (err_sticky !== 1'b0) $display("FAIL clr_final_sticky got %b want 0", err_sticky); else n_pass++;
  endtask

  task automatic test_saturation();
    drive_idle();
    set_lane(2, 0);
    stat_sel = PORT_N;
    for (int c = 0; c < 20; c++) begin
      tick();
      n_checks++; if (int'(stat_cnt) !== exp_stat())
        $display("FAIL sat_cnt cycle=%0d got %0d want %0d", c, stat_cnt, exp_stat()); else n_pass++;
    end
    n_checks++; if (int'(stat_cnt) !== CNT_MAX) $display("FAIL sat_cnt_final got %0d want %0d", stat_cnt, CNT_MAX); else n_pass++;
    reset_n = 1'b0;
    model_reset();
    #1;
    n_checks++; if (stat_cnt !== '0) $display("FAIL midreset_cnt got %0d want 0", stat_cnt); else n_pass++;
    n_checks++; if (bus.out_valid !== '0 || bus.out_flit !== '0)
      $display("FAIL midreset_out got valid=%b flit=%h want 0", bus.out_valid, bus.out_flit); else n_pass++;
    tick();
    drive_idle();
    reset_n = 1'b1;
    tick();
    n_checks++; if (stat_cnt !== '0) $display("FAIL post_reset_cnt got %0d want 0", stat_cnt); else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive_random(1'b1);
      tick();
      n_checks++; if (bus.out_valid !== exp_valid) $display("FAIL rnd_valid cyc=%0d got %b want %b", c, bus.out_valid, exp_valid); else n_pass++;
      n_checks++; if (bus.out_src !== exp_src) $display("FAIL rnd_src cyc=%0d got %h want %h", c, bus.out_src, exp_src); else n_pass++;
      n_checks++; if (bus.out_flit !== exp_flit) $display("FAIL rnd_flit cyc=%0d got %h want %h", c, bus.out_flit, exp_flit); else n_pass++;
      n_checks++; if ({conflict, illegal, err_sticky} !== {exp_conflict, exp_illegal, exp_sticky})
        $display("FAIL rnd_monitors cyc=%0d got %b want %b", c, {conflict, illegal, err_sticky},
                 {exp_conflict, exp_illegal, exp_sticky}); else n_pass++;
      n_checks++; if (int'(stat_cnt) !== exp_stat())
        $display("FAIL rnd_stat cyc=%0d sel=%0d got %0d want %0d", c, stat_sel, stat_cnt, exp_stat()); else n_pass++;
      n_checks++; if ($countones(bus.out_valid) > exp_in_pop)
        $display("FAIL rnd_popcount cyc=%0d got %0d want <=%0d", c, $countones(bus.out_valid), exp_in_pop); else n_pass++;
    end
  endtask

  initial begin
    drive_idle();
    model_reset();
    test_reset();
    test_permutation();
    test_conflict();
    test_illegal();
    test_clear_vs_error();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
